// File: rtl/dmem_arb_pkg.sv
// Shared types and default constants for the data-memory arbiter.
//   arb_state_t      : arbiter FSM state (IDLE, LOCK0, LOCK1)
//   DEF_WIDTH        : default data/address width
//   DEF_DEPTH_BYTES  : default valid byte-address range of the dmem
//   DEF_MAX_LOCK     : default maximum consecutive cycles a lock may be held
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  localparam int unsigned DEF_WIDTH       = 32;
  localparam int unsigned DEF_DEPTH_BYTES = 256;
  localparam int unsigned DEF_MAX_LOCK    = 8;

endpackage

// File: rtl/dmem_arbiter_rr2.sv
// Two-way round-robin picker.
//   req0, req1 : requests from port 0 and port 1
//   last       : port that won most recently (0 or 1)
//   gnt[1:0]   : one-hot grant; a lone requester always wins, on contention
//                the port that did not win last time is chosen
module arb_rr2 (
  input  logic       req0,
  input  logic       req1,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt    = '0;
    gnt[0] = req0 & (~req1 | last);
    gnt[1] = req1 & (~req0 | ~last);
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing one data memory between a CPU port (P0) and an
// auxiliary/DMA port (P1). The dmem itself lives outside this block.
//   CLK, RESET            : clock, synchronous active-high reset
//   Pn_REQ/LOCK/WE/A/WD   : per-port request, lock-hold, write enable,
//                           byte address, write data
//   Pn_GNT                : combinational grant for this cycle
//   Pn_VALID              : RDATA holds this port's read data (1 cycle after grant)
//   Pn_ERR                : previous granted access was out of range
//   RDATA                 : registered read data
//   MEM_WE/MEM_A/MEM_WD   : dmem write enable, address, write data
//   MEM_RD                : combinational dmem read data
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned DEPTH_BYTES = DEF_DEPTH_BYTES,
  parameter int unsigned MAX_LOCK    = DEF_MAX_LOCK
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             P0_REQ,
  input  logic             P1_REQ,
  input  logic             P0_LOCK,
  input  logic             P1_LOCK,
  input  logic             P0_WE,
  input  logic             P1_WE,
  input  logic [WIDTH-1:0] P0_A,
  input  logic [WIDTH-1:0] P1_A,
  input  logic [WIDTH-1:0] P0_WD,
  input  logic [WIDTH-1:0] P1_WD,
  output logic             P0_GNT,
  output logic             P1_GNT,
  output logic             P0_VALID,
  output logic             P1_VALID,
  output logic             P0_ERR,
  output logic             P1_ERR,
  output logic [WIDTH-1:0] RDATA,
  output logic             MEM_WE,
  output logic [WIDTH-1:0] MEM_A,
  output logic [WIDTH-1:0] MEM_WD,
  input  logic [WIDTH-1:0] MEM_RD
);

  localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MAX_LOCK - 1);
  localparam logic [WIDTH:0]   DEPTH_LIM = (WIDTH + 1)'(DEPTH_BYTES);

  arb_state_t       state;
  logic [CNT_W-1:0] lock_cnt;
  logic             last;       // port granted most recently
  logic             valid0_q, valid1_q, err0_q, err1_q;

  logic [1:0]       rr_gnt;
  logic [1:0]       gnt;
  logic             gnt_any;
  logic             sel_we;
  logic             in_range;

  arb_rr2 u_rr (
    .req0 (P0_REQ),
    .req1 (P1_REQ),
    .last (last),
    .gnt  (rr_gnt)
  );

  // A lock gives its owner the memory outright; the other port is refused
  // even when the owner is idle this cycle.
  always_comb begin
    gnt = '0;
    if (!RESET) begin
      unique case (state)
        IDLE:    gnt = rr_gnt;
        LOCK0:   gnt = {1'b0, P0_REQ};
        LOCK1:   gnt = {P1_REQ, 1'b0};
        default: gnt = '0;
      endcase
    end
  end

  always_comb begin
    gnt_any  = |gnt;
    MEM_A    = gnt[1] ? P1_A  : P0_A;
    MEM_WD   = gnt[1] ? P1_WD : P0_WD;
    sel_we   = gnt[1] ? P1_WE : P0_WE;
    in_range = {1'b0, MEM_A} < DEPTH_LIM;
    MEM_WE   = gnt_any & sel_we & in_range;
  end

  assign P0_GNT = gnt[0];
  assign P1_GNT = gnt[1];

  // Registered status is masked during reset so the cycle RESET rises
  // shows nothing left over from the access before it.
  assign P0_VALID = valid0_q & ~RESET;
  assign P1_VALID = valid1_q & ~RESET;
  assign P0_ERR   = err0_q & ~RESET;
  assign P1_ERR   = err1_q & ~RESET;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      lock_cnt <= '0;
      last     <= 1'b1;
      RDATA    <= '0;
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
    end else begin
      valid0_q <= gnt[0] & ~sel_we & in_range;
      valid1_q <= gnt[1] & ~sel_we & in_range;
      err0_q   <= gnt[0] & ~in_range;
      err1_q   <= gnt[1] & ~in_range;

      if (gnt_any && !sel_we && in_range)
        RDATA <= MEM_RD;

      if (gnt[0]) last <= 1'b0;
      if (gnt[1]) last <= 1'b1;

      // lock_cnt counts the owner's consecutive grants including the one
      // that opened the lock; the MAX_LOCK-th one forces IDLE, and since
      // the owner is then the last winner the other port is favoured next.
      unique case (state)
        IDLE: begin
          if (gnt[0] && P0_LOCK && MAX_LOCK > 1) begin
            state    <= LOCK0;
            lock_cnt <= CNT_W'(1);
          end else if (gnt[1] && P1_LOCK && MAX_LOCK > 1) begin
            state    <= LOCK1;
            lock_cnt <= CNT_W'(1);
          end
        end
        LOCK0: begin
          if (!P0_REQ || !P0_LOCK || lock_cnt == CNT_LAST) begin
            state    <= IDLE;
            lock_cnt <= '0;
          end else begin
            lock_cnt <= lock_cnt + CNT_W'(1);
          end
        end
        LOCK1: begin
          if (!P1_REQ || !P1_LOCK || lock_cnt == CNT_LAST) begin
            state    <= IDLE;
            lock_cnt <= '0;
          end else begin
            lock_cnt <= lock_cnt + CNT_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          lock_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small word-organised dmem model.
module tb_dmem_arbiter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        P0_REQ, P1_REQ, P0_LOCK, P1_LOCK, P0_WE, P1_WE;
  logic [31:0] P0_A, P1_A, P0_WD, P1_WD;
  logic        P0_GNT, P1_GNT, P0_VALID, P1_VALID, P0_ERR, P1_ERR;
  logic [31:0] RDATA;
  logic        MEM_WE;
  logic [31:0] MEM_A, MEM_WD, MEM_RD;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  logic [31:0] mem [0:63];

  always #5 CLK = ~CLK;

  dmem_arbiter #(.WIDTH(32), .DEPTH_BYTES(256), .MAX_LOCK(8)) dut (
    .CLK(CLK), .RESET(RESET),
    .P0_REQ(P0_REQ), .P1_REQ(P1_REQ), .P0_LOCK(P0_LOCK), .P1_LOCK(P1_LOCK),
    .P0_WE(P0_WE), .P1_WE(P1_WE), .P0_A(P0_A), .P1_A(P1_A),
    .P0_WD(P0_WD), .P1_WD(P1_WD),
    .P0_GNT(P0_GNT), .P1_GNT(P1_GNT), .P0_VALID(P0_VALID), .P1_VALID(P1_VALID),
    .P0_ERR(P0_ERR), .P1_ERR(P1_ERR), .RDATA(RDATA),
    .MEM_WE(MEM_WE), .MEM_A(MEM_A), .MEM_WD(MEM_WD), .MEM_RD(MEM_RD)
  );

  // External dmem: combinational read, write on the rising edge.
  assign MEM_RD = mem[MEM_A[7:2]];
  always @(posedge CLK)
    if (MEM_WE && MEM_A < 32'd256) mem[MEM_A[7:2]] <= MEM_WD;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_all();
    P0_REQ = 0; P1_REQ = 0; P0_LOCK = 0; P1_LOCK = 0; P0_WE = 0; P1_WE = 0;
    P0_A = '0; P1_A = '0; P0_WD = '0; P1_WD = '0;
  endtask

  // Move to the next cycle's drive point (falling edge).
  task automatic next_cycle();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    next_cycle();
    idle_all();
    RESET = 1;
    next_cycle();
    RESET = 0;
  endtask

  // Scenario 3 expected P1 grants per cycle: 8 locked grants, P0 on the 9th,
  // then P1 wins the next contention and relocks.
  logic [11:0] exp_g1_s3 = 12'b1110_1111_1111;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    idle_all();
    RESET = 1;

    // ---- reset behaviour: requests ignored while RESET is high
    next_cycle();
    P0_REQ = 1; P0_WE = 1; P1_REQ = 1; P1_WE = 1;
    #1;
    check("rst_g0", {31'b0, P0_GNT}, 0);
    check("rst_g1", {31'b0, P1_GNT}, 0);
    check("rst_mwe", {31'b0, MEM_WE}, 0);
    next_cycle();
    #1;
    check("rst_rdata", RDATA, 0);
    check("rst_v0", {31'b0, P0_VALID}, 0);
    check("rst_e0", {31'b0, P0_ERR}, 0);
    idle_all();
    RESET = 0;

    // ---- scenario 1: two writes then two reads
    next_cycle();
    P0_REQ = 1; P0_WE = 1; P0_A = 0; P0_WD = 10;
    #1;
    check("s1_w0_g0", {31'b0, P0_GNT}, 1);
    check("s1_w0_mwe", {31'b0, MEM_WE}, 1);
    next_cycle();
    idle_all();
    P1_REQ = 1; P1_WE = 1; P1_A = 252; P1_WD = 11;
    #1;
    check("s1_w1_g1", {31'b0, P1_GNT}, 1);
    check("s1_w1_g0", {31'b0, P0_GNT}, 0);
    check("s1_w1_mwe", {31'b0, MEM_WE}, 1);
    check("s1_w0_nov", {31'b0, P0_VALID}, 0);
    next_cycle();
    idle_all();
    P0_REQ = 1; P0_A = 0;
    #1;
    check("s1_r0_g0", {31'b0, P0_GNT}, 1);
    check("s1_r0_mwe", {31'b0, MEM_WE}, 0);
    check("s1_w1_nov", {31'b0, P1_VALID}, 0);
    next_cycle();
    idle_all();
    P1_REQ = 1; P1_A = 252;
    #1;
    check("s1_r1_g1", {31'b0, P1_GNT}, 1);
    check("s1_r0_v", {31'b0, P0_VALID}, 1);
    check("s1_r0_d", RDATA, 10);
    next_cycle();
    idle_all();
    #1;
    check("s1_r1_v", {31'b0, P1_VALID}, 1);
    check("s1_r1_d", RDATA, 11);
    check("s1_r0_v1cyc", {31'b0, P0_VALID}, 0);
    next_cycle();
    #1;
    check("s1_r1_v1cyc", {31'b0, P1_VALID}, 0);
    check("s1_hold", RDATA, 11);

    // ---- scenario 2: both read every cycle, alternating from P0
    do_reset();
    P0_REQ = 1; P0_A = 0; P1_REQ = 1; P1_A = 252;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("s2_g0", {31'b0, P0_GNT}, (i % 2 == 0) ? 1 : 0);
      check("s2_g1", {31'b0, P1_GNT}, (i % 2 == 0) ? 0 : 1);
      if (i > 0) check("s2_rd", RDATA, (i % 2 == 1) ? 10 : 11);
      next_cycle();
    end
    idle_all();

    // ---- scenario 3: P1 holds a lock against a requesting P0
    P0_REQ = 1; P0_A = 0;           // lone P0 access so P1 is favoured next
    next_cycle();
    P0_REQ = 1; P0_A = 0;
    P1_REQ = 1; P1_LOCK = 1; P1_A = 252;
    for (int i = 0; i < 12; i++) begin
      #1;
      check("s3_g1", {31'b0, P1_GNT}, {31'b0, exp_g1_s3[i]});
      check("s3_g0", {31'b0, P0_GNT}, {31'b0, ~exp_g1_s3[i]});
      next_cycle();
    end
    idle_all();
    next_cycle();                   // P1_REQ low releases the lock

    // ---- scenario 4: out-of-range write
    P0_REQ = 1; P0_WE = 1; P0_A = 256; P0_WD = 5;
    #1;
    check("s4_g0", {31'b0, P0_GNT}, 1);
    check("s4_mwe", {31'b0, MEM_WE}, 0);
    next_cycle();
    idle_all();
    #1;
    check("s4_err", {31'b0, P0_ERR}, 1);
    check("s4_nov", {31'b0, P0_VALID}, 0);
    next_cycle();
    P0_REQ = 1; P0_A = 0;
    #1;
    check("s4_err1cyc", {31'b0, P0_ERR}, 0);
    next_cycle();
    idle_all();
    #1;
    check("s4_rd_v", {31'b0, P0_VALID}, 1);
    check("s4_rd_d", RDATA, 10);

    // ---- scenario 5: reset during a P0 lock (P0 won last, so P1 would
    // win contention without the reset pointer)
    next_cycle();
    P0_REQ = 1; P0_LOCK = 1; P0_A = 252;
    #1;
    check("s5_c1_g0", {31'b0, P0_GNT}, 1);
    next_cycle();
    P1_REQ = 1; P1_A = 0;
    #1;
    check("s5_c2_g0", {31'b0, P0_GNT}, 1);
    check("s5_c2_g1", {31'b0, P1_GNT}, 0);
    next_cycle();
    RESET = 1;
    #1;
    check("s5_rst_g0", {31'b0, P0_GNT}, 0);
    check("s5_rst_g1", {31'b0, P1_GNT}, 0);
    check("s5_rst_v0", {31'b0, P0_VALID}, 0);
    next_cycle();
    RESET = 0; P0_LOCK = 0;
    #1;
    check("s5_post_g0", {31'b0, P0_GNT}, 1);
    check("s5_post_g1", {31'b0, P1_GNT}, 0);
    check("s5_post_v0", {31'b0, P0_VALID}, 0);
    check("s5_post_d", RDATA, 0);
    next_cycle();
    #1;
    check("s5_next_g1", {31'b0, P1_GNT}, 1);
    check("s5_next_v0", {31'b0, P0_VALID}, 1);
    check("s5_next_d", RDATA, 11);
    next_cycle();
    idle_all();
    next_cycle();

    // ---- scenario 6: inputs go unknown after a granted read
    P0_REQ = 1; P0_A = 252;
    #1;
    check("s6_g0", {31'b0, P0_GNT}, 1);
    next_cycle();
    P0_REQ = 0; P0_A = 'x; P0_WE = 1'bx;
    #1;
    check("s6_v", {31'b0, P0_VALID}, 1);
    check("s6_d", RDATA, 11);
    check("s6_mwe", {31'b0, MEM_WE}, 0);
    next_cycle();
    #1;
    check("s6_v1cyc", {31'b0, P0_VALID}, 0);
    check("s6_hold", RDATA, 11);
    idle_all();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, which sets the data and address width.
REQ-002 The block SHALL have parameter DEPTH_BYTES, default 256, which sets the valid byte-address range of the shared dmem (0..DEPTH_BYTES-1).
REQ-003 The block SHALL have parameter MAX_LOCK, default 8, which sets the maximum consecutive cycles one port may hold a lock.
REQ-004 Port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port RESET, input, 1 bit: synchronous, active-high reset.
REQ-006 Ports P0_REQ / P1_REQ, input, 1 bit each: access request from port 0 (CPU) and port 1 (auxiliary/DMA).
REQ-007 Ports P0_LOCK / P1_LOCK, input, 1 bit each: hold the grant for the following cycle.
REQ-008 Ports P0_WE / P1_WE, input, 1 bit each: write enable of the request.
REQ-009 Ports P0_A / P1_A, input, WIDTH bits each: byte address.
REQ-010 Ports P0_WD / P1_WD, input, WIDTH bits each: write data.
REQ-011 Ports P0_GNT / P1_GNT, output, 1 bit each: request accepted this cycle (combinational).
REQ-012 Ports P0_VALID / P1_VALID, output, 1 bit each: read data valid on RDATA this cycle.
REQ-013 Port P0_ERR / P1_ERR, output, 1 bit each: the previous granted access was out of range.
REQ-014 Port RDATA, output, WIDTH bits: registered read data.
REQ-015 Ports MEM_WE (1 bit), MEM_A (WIDTH bits), MEM_WD (WIDTH bits), output: drive the dmem WE/A/WD.
REQ-016 Port MEM_RD, input, WIDTH bits: combinational dmem read data.

Function
REQ-017 At most one GNT SHALL be high per cycle; a GNT is only asserted when the corresponding REQ is high.
REQ-018 When only one port requests, that port SHALL be granted in the same cycle.
REQ-019 When both request in state IDLE, the port not granted most recently SHALL win; after reset port 0 SHALL win.
REQ-020 MEM_A, MEM_WD and MEM_WE SHALL mirror the granted port; MEM_WE = 0 when no grant, the address is out of range, or the granted WE = 0.
REQ-021 A granted read SHALL capture MEM_RD into RDATA at the edge, with the port's VALID high for exactly the next cycle (latency 1).
REQ-022 A granted write SHALL commit at the grant edge and SHALL NOT raise VALID.
REQ-023 An address >= DEPTH_BYTES SHALL suppress the write and any VALID, and SHALL raise the port's ERR for one cycle.
REQ-024 The FSM SHALL have states IDLE, LOCK0 and LOCK1.
REQ-025 IDLE -> LOCKn when port n is granted with LOCK high.
REQ-026 In LOCKn, port n SHALL have absolute priority; the other port SHALL be refused even if port n has no request.
REQ-027 LOCKn -> IDLE when LOCKn is low at a grant edge, or when REQn is low.
REQ-028 A lock counter SHALL count cycles spent in LOCKn; on the MAX_LOCK-th cycle the FSM SHALL force IDLE and the last-winner pointer SHALL favour the other port.
REQ-029 When REQ, WE and address change on the same cycle as lock release, the new arbitration SHALL apply to the following cycle only.

Reset
REQ-030 While RESET is high, the block SHALL set the state to IDLE, clear the lock counter, set last-winner = port 1, and set RDATA = 0.
REQ-031 While RESET is high, the block SHALL drive VALID and ERR low, all GNT low and MEM_WE = 0, regardless of REQ.
REQ-032 When reset occurs mid-lock, the lock SHALL be discarded, and no VALID SHALL be issued for an access granted in the reset cycle.

Structure
REQ-033 The state enum (IDLE, LOCK0, LOCK1) and the default WIDTH/MAX_LOCK constants SHALL live in package dmem_arb_pkg.
REQ-034 The two-way round-robin picker SHALL be a sub-module arb_rr2 (inputs: two requests and the pointer; output: one-hot grant).
REQ-035 The dmem SHALL NOT be instantiated inside the block; it SHALL be connected at the pipeline top level.

Verification
REQ-036 Scenario 1: P0 writes 10 to A=0, then P1 writes 11 to A=252 in the next cycle -> both GNT are given in order, and later reads return 10 and 11 with VALID one cycle after GNT.
REQ-037 Scenario 2: both ports request a read every cycle with no lock -> grants alternate P0, P1, P0, P1, starting with P0 after reset.
REQ-038 Scenario 3: P1 is locked with REQ/LOCK high for 12 cycles while P0 also requests -> P1 gets exactly 8 grants, then P0 is granted on cycle 9.
REQ-039 Scenario 4: P0 writes 5 to A=256 -> P0_ERR is high for one cycle, MEM_WE stays 0, and a read of A=0 still returns the previous value.
REQ-040 Scenario 5: RESET is asserted on the third cycle of a P0 lock -> the state returns to IDLE, no VALID occurs, and the next contended grant goes to P0.
REQ-041 Scenario 6: a P0 read is granted with the address and WE driven X in the following cycle -> RDATA holds the captured word and VALID is high for exactly one cycle.
